// File: rtl/v_issue_seq.sv
// v_issue_seq: vector issue sequencer; splits one decoded instruction into LANES-wide beats for one functional unit.
// Latency: a vconfig completes in 1 cycle; an instruction with N beats reports instr_done N+2 cycles after accept.
// Backpressure: dec_ready is high only in IDLE; a beat holds fu_valid, beat_idx and elem_mask until fu_ready of its unit.
// Optional feature macro: V_ISSUE_PERF_EN adds a saturating 32-bit stall_cnt output.
module v_issue_seq #(
  parameter int LANES = 4,
  parameter int VLMAX = 32,
  localparam int BW = $clog2(VLMAX / LANES + 1),
  localparam int VW = $clog2(VLMAX + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic             is_vconfig,
  input  logic [31:0]      avl,
  input  logic [2:0]       fu_sel,
  output logic [4:0]       fu_valid,
  input  logic [4:0]       fu_ready,
  input  logic [4:0]       fu_done,
  input  logic             abort,
  output logic [BW-1:0]    beat_idx,
  output logic [LANES-1:0] elem_mask,
  output logic [VW-1:0]    vl,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal
`ifdef V_ISSUE_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    vl_q, vl_d;
  logic [2:0]       sel_q, sel_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [BW-1:0]    last_q, last_d;
  logic [4:0]       fv_q, fv_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic             done_q, done_d;
  logic             ill_q, ill_d;
  logic             illflag_q, illflag_d;
`ifdef V_ISSUE_PERF_EN
  logic [31:0]      stall_q, stall_d;
  logic             fv_sel;
`endif

  logic       accept;
  logic       rdy_sel;
  logic       done_sel;
  logic [7:0] rdy_ext;
  logic [7:0] done_ext;

  // Active lanes of beat b: lane i carries element b*LANES+i, which is live only below vl.
  // Every beat before the last is automatically full, so one formula covers all beats.
  function automatic logic [LANES-1:0] lane_mask(input logic [BW-1:0] b, input logic [VW-1:0] v);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = ((32'(b) * 32'(LANES)) + 32'(i)) < 32'(v);
    end
    return m;
  endfunction

  // Zero-extend the per-unit inputs so an index of 5..7 reads 0 rather than out of range.
  assign rdy_ext  = {3'b000, fu_ready};
  assign done_ext = {3'b000, fu_done};
  assign rdy_sel  = rdy_ext[sel_q];
  assign done_sel = done_ext[sel_q];
  assign accept   = dec_valid && (state_q == IDLE);

  // Next-state and datapath: handshake, beat stepping, drain wait, abort priority.
  always_comb begin
    state_d   = state_q;
    vl_d      = vl_q;
    sel_d     = sel_q;
    beat_d    = beat_q;
    last_d    = last_q;
    fv_d      = fv_q;
    done_d    = 1'b0;
    ill_d     = 1'b0;
    illflag_d = illflag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_vconfig) begin
            vl_d   = (avl > 32'(VLMAX)) ? VW'(VLMAX) : VW'(avl);
            done_d = 1'b1;
          end else begin
            sel_d  = fu_sel;
            beat_d = '0;
            if (fu_sel > 3'd4) begin
              illflag_d = 1'b1;
              state_d   = DONE;
            end else if (vl_q == '0) begin
              illflag_d = 1'b0;
              state_d   = DONE;
            end else begin
              illflag_d = 1'b0;
              // ceil(vl/LANES)-1 == floor((vl-1)/LANES) for vl >= 1
              last_d    = BW'((32'(vl_q) - 32'd1) / 32'(LANES));
              fv_d      = 5'b00001 << fu_sel;
              state_d   = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          fv_d    = '0;
          state_d = IDLE;
        end else if (rdy_sel) begin
          if (beat_q == last_q) begin
            fv_d    = '0;
            // completion seen together with the last-beat accept skips DRAIN
            state_d = done_sel ? DONE : DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (done_sel) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        ill_d   = illflag_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mask_d = (state_d == ISSUE) ? lane_mask(beat_d, vl_d) : '0;
  end

`ifdef V_ISSUE_PERF_EN
  // Count cycles where the selected unit is offered a beat but refuses it; stick at all ones.
  assign fv_sel = fv_q[sel_q[2:0] > 3'd4 ? 3'd0 : sel_q] && (sel_q <= 3'd4);
  always_comb begin
    stall_d = stall_q;
    if (fv_sel && !rdy_sel && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end
  assign stall_cnt = stall_q;
`endif

  // State and registered outputs; reset drops any in-flight instruction without a done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      vl_q      <= VW'(VLMAX);
      sel_q     <= '0;
      beat_q    <= '0;
      last_q    <= '0;
      fv_q      <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
      illflag_q <= 1'b0;
`ifdef V_ISSUE_PERF_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vl_q      <= vl_d;
      sel_q     <= sel_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      fv_q      <= fv_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      ill_q     <= ill_d;
      illflag_q <= illflag_d;
`ifdef V_ISSUE_PERF_EN
      stall_q   <= stall_d;
`endif
    end
  end

  assign dec_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign fu_valid   = fv_q;
  assign beat_idx   = beat_q;
  assign elem_mask  = mask_q;
  assign vl         = vl_q;
  assign instr_done = done_q;
  assign illegal    = ill_q;

endmodule
